ch_point_buf: RTL and testbench
===============================

// Module: ch_point_buf
// PURPOSE
//  Point buffer directly downstream of the channel measurement controller.
//  Captures each {threshold, delay code} point on the controller's one-cycle
//  point-ready pulse into a FIFO; software pops points through a pop strobe.
//  Counts dropped points and raises a level interrupt for batch readout.
// PARAMETERS
//  DEPTH      64   FIFO entries; power of two, >= 4; AW = $clog2(DEPTH)
//  OVF_W      16   width of the dropped-point counter
// PORTS
//  clk_i        in   1      clock
//  rst_i        in   1      reset, synchronous, active-high
//  point_rdy_i  in   1      one-cycle pulse: new measured point
//  point_v_i    in   16     measured threshold value
//  point_t_i    in   10     measured delay code
//  clear_i      in   1      flush buffer and overflow counter (e.g. on run start)
//  rd_i         in   1      pop strobe, one entry per asserted cycle
//  rd_data_o    out  32     {point_t[9:0], 6'b0, point_v[15:0]}
//  rd_valid_o   out  1      rd_data_o valid (one-cycle pulse)
//  count_o      out  AW+1   entries stored, 0..DEPTH
//  empty_o      out  1      count_o == 0
//  full_o       out  1      count_o == DEPTH
//  ovf_cnt_o    out  OVF_W  points dropped since last clear, saturating
//  level_i      in   AW+1   IRQ threshold; 0 disables IRQ
//  irq_o        out  1      sticky level interrupt
//  irq_clr_i    in   1      clear irq_o
// BEHAVIOUR
//  - Reset (rst_i=1 at posedge): pointers=0, count_o=0, empty_o=1, full_o=0,
//    rd_data_o=0, rd_valid_o=0, ovf_cnt_o=0, irq_o=0. rst_i wins over everything.
//  - Write: point_rdy_i && !full -> store entry, wr_ptr++ (wraps mod DEPTH).
//    point_rdy_i && full -> entry dropped, ovf_cnt_o++ (saturates at all-ones).
//  - Read: rd_i && !empty -> rd_data_o = entry at rd_ptr on the next clock edge,
//    rd_valid_o=1 for exactly that cycle, rd_ptr++ (wraps). rd_i && empty ->
//    ignored, rd_valid_o=0, rd_data_o holds its value. No write-to-read bypass.
//  - Same cycle rd_i && point_rdy_i:
//    not empty -> both performed, count unchanged (holds when full: no drop).
//    empty -> write only; rd_i is ignored.
//  - count_o, empty_o, full_o are registered and reflect all operations
//    completed at the previous edge.
//  - clear_i: pointers=0, count=0, ovf_cnt_o=0 next cycle. Same-cycle rd_i and
//    point_rdy_i are discarded; rd_valid_o=0. irq_o is unaffected.
//  - IRQ: when level_i!=0 && count_o>=level_i (registered count), irq_o is set
//    next cycle. irq_clr_i clears it. Set beats clear in the same cycle, so
//    irq_o re-asserts while the condition holds.
//  - Storage is an inferred RAM: one synchronous write port and one synchronous
//    read port. Data memory contents are not reset.
// CONFIGURATION
//  CH_POINT_BUF_TS_EN defined: a 32-bit free-running cycle counter (reset 0,
//    wraps) is stored with each entry. Extra port rd_ts_o out 32 updates with
//    rd_data_o (reset 0). The timestamp is the counter value in the cycle
//    point_rdy_i was high.
//  Not defined: no counter and no rd_ts_o port; entries are 26 bits wide.
// TESTING
//  1 Reset, write 3 points (v=0x0010/t=1, 0x0020/2, 0x0030/3), then 3 rd_i ->
//    rd_data_o = 0x00400010, 0x00800020, 0x00C00030 in order; count_o 3->0,
//    empty_o=1.
//  2 Write DEPTH+5 points, no reads -> full_o=1, count_o=DEPTH, ovf_cnt_o=5;
//    reads return the first DEPTH points only.
//  3 Full buffer, rd_i and point_rdy_i in the same cycle -> no drop,
//    count_o stays DEPTH, ovf_cnt_o unchanged, oldest entry popped.
//  4 Empty buffer, rd_i and point_rdy_i in the same cycle -> rd_valid_o=0,
//    count_o=1; next rd_i returns that point.
//  5 level_i=4: 4th write -> irq_o=1 one cycle after count_o=4. irq_clr_i with
//    count 4 -> irq_o stays 1. Pop 1, then irq_clr_i -> irq_o=0. level_i=0 -> never set.
//  6 clear_i with count=10, ovf=2 and a same-cycle point_rdy_i -> count_o=0,
//    ovf_cnt_o=0, empty_o=1. rst_i mid-stream -> all outputs back to reset values.
//    With CH_POINT_BUF_TS_EN: rd_ts_o delta equals the cycle gap between writes.

Source files
------------

// File: rtl/ch_point_buf.sv
// Point buffer behind the channel measurement controller: FIFO of {threshold, delay code},
// dropped-point counter and level IRQ. Define CH_POINT_BUF_TS_EN to store a cycle timestamp per entry.
module ch_point_buf #(
    parameter  int DEPTH = 64,
    parameter  int OVF_W = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              point_rdy_i,
    input  logic [15:0]       point_v_i,
    input  logic [9:0]        point_t_i,
    input  logic              clear_i,
    input  logic              rd_i,
    output logic [31:0]       rd_data_o,
    output logic              rd_valid_o,
    output logic [AW:0]       count_o,
    output logic              empty_o,
    output logic              full_o,
    output logic [OVF_W-1:0]  ovf_cnt_o,
    input  logic [AW:0]       level_i,
    output logic              irq_o,
    input  logic              irq_clr_i
`ifdef CH_POINT_BUF_TS_EN
    ,
    output logic [31:0]       rd_ts_o
`endif
);

`ifdef CH_POINT_BUF_TS_EN
    localparam int EW = 58;
`else
    localparam int EW = 26;
`endif

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count_q;
    logic [EW-1:0] wr_entry;
    logic [EW-1:0] rd_entry;
    logic          wr_en, rd_en, drop;

    assign count_o = count_q;
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));

    // A full buffer still accepts a point when a pop retires an entry in the same cycle.
    assign rd_en = rd_i && !empty_o && !clear_i;
    assign wr_en = point_rdy_i && (!full_o || rd_i) && !clear_i;
    assign drop  = point_rdy_i && full_o && !rd_i && !clear_i;

`ifdef CH_POINT_BUF_TS_EN
    logic [31:0] ts_q;
    assign wr_entry = {ts_q, point_t_i, point_v_i};
`else
    assign wr_entry = {point_t_i, point_v_i};
`endif

    assign rd_entry = mem[rd_ptr];

    // Storage has no reset so it maps onto a simple dual-port RAM.
    always_ff @(posedge clk_i) begin
        if (wr_en)
            mem[wr_ptr] <= wr_entry;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            rd_data_o  <= '0;
            rd_valid_o <= 1'b0;
            ovf_cnt_o  <= '0;
            irq_o      <= 1'b0;
        end else begin
            rd_valid_o <= rd_en;
            if (rd_en)
                rd_data_o <= {rd_entry[25:16], 6'b0, rd_entry[15:0]};
            if (clear_i) begin
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                count_q   <= '0;
                ovf_cnt_o <= '0;
            end else begin
                if (wr_en)
                    wr_ptr <= wr_ptr + AW'(1);
                if (rd_en)
                    rd_ptr <= rd_ptr + AW'(1);
                count_q <= count_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
                if (drop && (ovf_cnt_o != '1))
                    ovf_cnt_o <= ovf_cnt_o + OVF_W'(1);
            end
            // Set has priority so the IRQ re-fires while the level is still met.
            if ((level_i != '0) && (count_q >= level_i))
                irq_o <= 1'b1;
            else if (irq_clr_i)
                irq_o <= 1'b0;
        end
    end

`ifdef CH_POINT_BUF_TS_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ts_q    <= '0;
            rd_ts_o <= '0;
        end else begin
            ts_q <= ts_q + 32'd1;
            if (rd_en)
                rd_ts_o <= rd_entry[57:26];
        end
    end
`endif

endmodule

// File: tb/tb_ch_point_buf.sv
// Randomized + directed bench for ch_point_buf against a queue-based reference model.
module tb_ch_point_buf;
    localparam int DEPTH   = 16;
    localparam int OVF_W   = 4;
    localparam int AW      = $clog2(DEPTH);
    localparam int OVF_MAX = (1 << OVF_W) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b0, pt = 1'b0, clr = 1'b0, rd = 1'b0, iclr = 1'b0;
    logic [15:0]       pv = '0;
    logic [9:0]        ptt = '0;
    logic [AW:0]       lvl = '0;
    logic [31:0]       rd_data;
    logic              rd_valid, empty, full, irq;
    logic [AW:0]       count;
    logic [OVF_W-1:0]  ovf;
`ifdef CH_POINT_BUF_TS_EN
    logic [31:0]       rd_ts;
`endif

    ch_point_buf #(.DEPTH(DEPTH), .OVF_W(OVF_W)) dut (
        .clk_i(clk), .rst_i(rst), .point_rdy_i(pt), .point_v_i(pv), .point_t_i(ptt),
        .clear_i(clr), .rd_i(rd), .rd_data_o(rd_data), .rd_valid_o(rd_valid),
        .count_o(count), .empty_o(empty), .full_o(full), .ovf_cnt_o(ovf),
        .level_i(lvl), .irq_o(irq), .irq_clr_i(iclr)
`ifdef CH_POINT_BUF_TS_EN
        , .rd_ts_o(rd_ts)
`endif
    );

    always #5 clk = ~clk;

    // reference model state
    logic [57:0] q[$];
    int          ovf_m = 0;
    logic [31:0] rdd_m = '0, rdts_m = '0, ts_m = '0;
    bit          rdv_m = 0, irq_m = 0;
    int          nvec = 0, nerr = 0;
    logic [31:0] ts_a, ts_b;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [57:0] e;
        int n;
        bit popped;
        if (rst) begin
            q.delete(); ovf_m = 0; rdd_m = '0; rdv_m = 0; irq_m = 0; ts_m = '0; rdts_m = '0;
        end else begin
            n = q.size();
            if (lvl != 0 && n >= int'(lvl)) irq_m = 1;
            else if (iclr) irq_m = 0;
            rdv_m = 0;
            if (clr) begin
                q.delete(); ovf_m = 0;
            end else begin
                popped = 0;
                if (rd && n > 0) begin
                    e = q.pop_front();
                    rdd_m = {e[25:16], 6'b0, e[15:0]};
                    rdts_m = e[57:26];
                    rdv_m = 1; popped = 1;
                end
                if (pt) begin
                    if (n < DEPTH || popped) q.push_back({ts_m, ptt, pv});
                    else if (ovf_m < OVF_MAX) ovf_m++;
                end
            end
            ts_m = ts_m + 32'd1;
        end
    endtask

    // Drive at negedge, let the edge happen, then compare every output against the model.
    task automatic step(input bit r, input bit p, input bit rr, input bit c, input bit ic,
                        input logic [15:0] v, input logic [9:0] t);
        rst = r; pt = p; rd = rr; clr = c; iclr = ic; pv = v; ptt = t;
        @(posedge clk);
        model_step();
        #1;
        chk("count", 64'(count), 64'(q.size()));
        chk("empty", 64'(empty), 64'(q.size() == 0));
        chk("full", 64'(full), 64'(q.size() == DEPTH));
        chk("ovf", 64'(ovf), 64'(ovf_m));
        chk("rd_valid", 64'(rd_valid), 64'(rdv_m));
        chk("rd_data", 64'(rd_data), 64'(rdd_m));
        chk("irq", 64'(irq), 64'(irq_m));
`ifdef CH_POINT_BUF_TS_EN
        chk("rd_ts", 64'(rd_ts), 64'(rdts_m));
`endif
        @(negedge clk);
    endtask

    task automatic idle(); step(0, 0, 0, 0, 0, '0, '0); endtask
    task automatic wr(input logic [15:0] v, input logic [9:0] t); step(0, 1, 0, 0, 0, v, t); endtask
    task automatic pop(); step(0, 0, 1, 0, 0, '0, '0); endtask

    initial begin
        @(negedge clk);
        step(1, 0, 0, 0, 0, '0, '0);
        step(1, 1, 1, 1, 1, 16'hffff, 10'h3ff);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);

        // basic ordering
        wr(16'h0010, 10'd1); wr(16'h0020, 10'd2); wr(16'h0030, 10'd3);
        chk("t1_count3", 64'(count), 64'd3);
        pop(); chk("t1_d0", 64'(rd_data), 64'h00400010);
        pop(); chk("t1_d1", 64'(rd_data), 64'h00800020);
        pop(); chk("t1_d2", 64'(rd_data), 64'h00C00030);
        chk("t1_empty", 64'(empty), 64'd1);

        // overflow past full
        for (int i = 0; i < DEPTH + 5; i++) wr(16'(i + 100), 10'(i));
        chk("t2_full", 64'(full), 64'd1);
        chk("t2_ovf", 64'(ovf), 64'd5);
        // full + simultaneous read/write: no drop
        step(0, 1, 1, 0, 0, 16'hbeef, 10'h155);
        chk("t3_count", 64'(count), 64'(DEPTH));
        chk("t3_ovf", 64'(ovf), 64'd5);
        chk("t3_data", 64'(rd_data), 64'({10'd0, 6'b0, 16'd100}));
        for (int i = 0; i < DEPTH + 2; i++) pop();

        // empty + simultaneous read/write: write only
        step(0, 1, 1, 0, 0, 16'h1234, 10'h2aa);
        chk("t4_valid", 64'(rd_valid), 64'd0);
        chk("t4_count", 64'(count), 64'd1);
        pop(); chk("t4_data", 64'(rd_data), 64'({10'h2aa, 6'b0, 16'h1234}));

        // level IRQ
        lvl = 4;
        for (int i = 0; i < 4; i++) wr(16'(i), 10'(i));
        chk("t5_irq_pre", 64'(irq), 64'd0);
        idle(); chk("t5_irq_set", 64'(irq), 64'd1);
        step(0, 0, 0, 0, 1, '0, '0); chk("t5_irq_hold", 64'(irq), 64'd1);
        pop(); step(0, 0, 0, 0, 1, '0, '0); chk("t5_irq_clr", 64'(irq), 64'd0);
        lvl = 0;
        for (int i = 0; i < 6; i++) wr(16'(i), 10'(i));
        chk("t5_irq_off", 64'(irq), 64'd0);

        // clear with count=10, ovf=2 and a same-cycle point
        step(0, 0, 0, 1, 0, '0, '0);
        for (int i = 0; i < DEPTH + 2; i++) wr(16'(i), 10'(i));
        for (int i = 0; i < DEPTH - 10; i++) pop();
        chk("t6_pre_count", 64'(count), 64'd10);
        chk("t6_pre_ovf", 64'(ovf), 64'd2);
`ifdef CH_POINT_BUF_TS_EN
        step(0, 0, 0, 1, 0, '0, '0);
        wr(16'h1, 10'h1); idle(); idle(); wr(16'h2, 10'h2);
        pop(); ts_a = rd_ts; pop(); ts_b = rd_ts;
        chk("ts_delta", 64'(ts_b - ts_a), 64'd3);
        for (int i = 0; i < 10; i++) wr(16'(i), 10'(i));
        for (int i = 0; i < DEPTH; i++) wr(16'(i), 10'(i));
        for (int i = 0; i < DEPTH - 10; i++) pop();
        step(0, 0, 0, 0, 0, '0, '0);
`endif
        step(0, 1, 1, 1, 0, 16'h5555, 10'h1);
        chk("t6_count", 64'(count), 64'd0);
        chk("t6_ovf", 64'(ovf), 64'd0);
        chk("t6_empty", 64'(empty), 64'd1);
        wr(16'h7, 10'h7); wr(16'h8, 10'h8); pop();
        step(1, 1, 1, 0, 0, 16'h9, 10'h9);
        chk("t6_rst_data", 64'(rd_data), 64'd0);
        chk("t6_rst_count", 64'(count), 64'd0);

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 63) == 0) lvl = (AW+1)'($urandom_range(0, DEPTH));
            step($urandom_range(0, 499) == 0,
                 $urandom_range(0, 99) < ((i / 500) % 2 ? 70 : 40),
                 $urandom_range(0, 99) < ((i / 500) % 2 ? 30 : 60),
                 $urandom_range(0, 149) == 0,
                 $urandom_range(0, 9) == 0,
                 16'($urandom), 10'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
